// File: rtl/cbrt_iter_pkg.sv
// Shared definitions for the iterative cube-root unit: FSM encoding and
// helpers for derived widths.
package cbrt_iter_pkg;

  typedef enum logic [1:0] {
    S_IDLE,
    S_SHIFT,
    S_WAIT,
    S_CHECK
  } state_t;

  // Number of 3-bit groups in a w-bit operand.
  function automatic int num_iter(input int w);
    return (w + 2) / 3;
  endfunction

  // Width of the trial value b = (3*y*(y+1)+1) << s, wide enough to avoid truncation.
  function automatic int trial_w(input int w);
    return 2 * w + 2;
  endfunction

endpackage

// File: rtl/cbrt_iter_mul_shift_add.sv
// Sequential shift-add multiplier: one partial product per cycle, product
// valid when busy_o falls, DATA_W cycles after the accepting edge.
module mul_shift_add #(
  parameter int DATA_W = 8
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  start_i,
  input  logic [DATA_W-1:0]     a_bi,
  input  logic [DATA_W-1:0]     b_bi,
  output logic                  busy_o,
  output logic [2*DATA_W-1:0]   y_bo
);

  localparam int CNT_W = $clog2(DATA_W + 1);

  logic [2*DATA_W-1:0] mcand_reg;
  logic [2*DATA_W-1:0] acc_reg;
  logic [DATA_W-1:0]   mplier_reg;
  logic [CNT_W-1:0]    cnt_reg;
  logic                busy_reg;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      mcand_reg  <= '0;
      acc_reg    <= '0;
      mplier_reg <= '0;
      cnt_reg    <= '0;
      busy_reg   <= 1'b0;
    end else if (!busy_reg) begin
      if (start_i) begin
        mcand_reg  <= {{DATA_W{1'b0}}, a_bi};
        mplier_reg <= b_bi;
        acc_reg    <= '0;
        cnt_reg    <= CNT_W'(DATA_W);
        busy_reg   <= 1'b1;
      end
    end else begin
      if (mplier_reg[0]) acc_reg <= acc_reg + mcand_reg;
      mcand_reg  <= mcand_reg << 1;
      mplier_reg <= mplier_reg >> 1;
      cnt_reg    <= cnt_reg - CNT_W'(1);
      if (cnt_reg == CNT_W'(1)) busy_reg <= 1'b0;
    end
  end

  assign busy_o = busy_reg;
  assign y_bo   = acc_reg;

endmodule

// File: rtl/cbrt_iter.sv
// Iterative integer cube root y = floor(cbrt(a)), restoring algorithm over
// 3-bit groups, with y*(y+1) formed by the shared shift-add multiplier.
module cbrt_iter
  import cbrt_iter_pkg::*;
#(
  parameter int DATA_W  = 8,
  parameter int MUL_LAT = DATA_W
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              start_i,
  input  logic [DATA_W-1:0] a_bi,
  output logic              busy_o,
  output logic [DATA_W-1:0] y_bo
);

  localparam int NUM_ITER = num_iter(DATA_W);
  localparam int S_W      = $clog2(3 * NUM_ITER);
  localparam int B_W      = trial_w(DATA_W);
  localparam int W_W      = $clog2(MUL_LAT + 1);

  state_t              state_reg;
  logic [DATA_W-1:0]   x_reg;
  logic [DATA_W-1:0]   y_reg;
  logic [DATA_W-1:0]   y_out_reg;
  logic [S_W-1:0]      s_reg;
  logic [W_W-1:0]      wait_reg;
  logic                busy_reg;

  logic                mul_start;
  logic                mul_busy;
  logic [DATA_W-1:0]   mul_a;
  logic [DATA_W-1:0]   mul_b;
  logic [2*DATA_W-1:0] mul_p;

  logic [B_W-1:0]      b_base;
  logic [B_W-1:0]      b_val;
  logic                fits;
  logic [DATA_W-1:0]   x_next;
  logic [DATA_W-1:0]   y_next;

  // Operands come from y before its doubling lands, so the product is ready for CHECK.
  assign mul_start = (state_reg == S_SHIFT);
  assign mul_a     = y_reg << 1;
  assign mul_b     = (y_reg << 1) + DATA_W'(1);

  mul_shift_add #(
    .DATA_W (DATA_W)
  ) u_mul (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .start_i (mul_start),
    .a_bi    (mul_a),
    .b_bi    (mul_b),
    .busy_o  (mul_busy),
    .y_bo    (mul_p)
  );

  assign b_base = (B_W'(mul_p) << 1) + B_W'(mul_p) + B_W'(1);
  assign b_val  = b_base << s_reg;
  assign fits   = (B_W'(x_reg) >= b_val);

  always_comb begin
    x_next = x_reg;
    y_next = y_reg;
    if (fits) begin
      x_next = x_reg - b_val[DATA_W-1:0];
      y_next = y_reg + DATA_W'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_reg <= S_IDLE;
      x_reg     <= '0;
      y_reg     <= '0;
      y_out_reg <= '0;
      s_reg     <= '0;
      wait_reg  <= '0;
      busy_reg  <= 1'b0;
    end else begin
      case (state_reg)
        S_IDLE: begin
          if (start_i) begin
            x_reg     <= a_bi;
            y_reg     <= '0;
            s_reg     <= S_W'(3 * (NUM_ITER - 1));
            busy_reg  <= 1'b1;
            state_reg <= S_SHIFT;
          end
        end
        S_SHIFT: begin
          y_reg     <= y_reg << 1;
          wait_reg  <= W_W'(MUL_LAT - 1);
          state_reg <= S_WAIT;
        end
        S_WAIT: begin
          // MUL_LAT must equal the multiplier's DATA_W-step latency.
          if (wait_reg == '0) state_reg <= S_CHECK;
          else                wait_reg  <= wait_reg - W_W'(1);
        end
        S_CHECK: begin
          x_reg <= x_next;
          y_reg <= y_next;
          if (s_reg == '0) begin
            y_out_reg <= y_next;
            busy_reg  <= 1'b0;
            state_reg <= S_IDLE;
          end else begin
            s_reg     <= s_reg - S_W'(3);
            state_reg <= S_SHIFT;
          end
        end
        default: state_reg <= S_IDLE;
      endcase
    end
  end

  assign busy_o = busy_reg;
  assign y_bo   = y_out_reg;

endmodule

// File: tb/tb_cbrt_iter.sv
// Self-checking bench for cbrt_iter: random and directed operands against a
// search-based cube-root model, plus handshake, latency and reset scenarios.
module tb_cbrt_iter;

  localparam int LAT = 30;

  logic       clk_i = 1'b0;
  logic       rst_i;
  logic       start_i;
  logic [7:0] a_bi;
  logic       busy_o;
  logic [7:0] y_bo;

  int total = 0;
  int bad   = 0;

  always #5 clk_i = ~clk_i;

  cbrt_iter #(.DATA_W(8), .MUL_LAT(8)) dut (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .start_i (start_i),
    .a_bi    (a_bi),
    .busy_o  (busy_o),
    .y_bo    (y_bo)
  );

  function automatic int ref_cbrt(input int a);
    int k = 0;
    while ((k + 1) * (k + 1) * (k + 1) <= a) k++;
    return k;
  endfunction

  function automatic int ref_isqrt(input int a);
    int k = 0;
    while ((k + 1) * (k + 1) <= a) k++;
    return k;
  endfunction

  // One operation from an idle cycle; returns result and busy cycle count.
  task automatic run_op(input logic [7:0] a, output logic [7:0] y, output int lat);
    int guard;
    @(negedge clk_i); start_i = 1'b1; a_bi = a;
    @(negedge clk_i); start_i = 1'b0; a_bi = 8'($urandom);
    lat = 0; guard = 0;
    while (busy_o === 1'b1 && guard < 100) begin
      lat++; guard++;
      @(negedge clk_i);
    end
    y = y_bo;
  endtask

  task automatic test_reset;
    rst_i = 1'b1; start_i = 1'b1; a_bi = 8'd200;
    repeat (3) @(negedge clk_i);
    total++;
    if (busy_o !== 1'b0) begin bad++; $display("FAIL reset_busy got=%0b exp=0", busy_o); end
    total++;
    if (y_bo !== 8'd0) begin bad++; $display("FAIL reset_y got=%0d exp=0", y_bo); end
    start_i = 1'b0; rst_i = 1'b0;
    @(negedge clk_i);
    total++;
    if (busy_o !== 1'b0) begin bad++; $display("FAIL reset_idle got=%0b exp=0", busy_o); end
  endtask

  task automatic test_cubes;
    logic [7:0] y; int lat;
    for (int j = 0; j <= 4; j++) begin
      run_op(8'(j * j * j), y, lat);
      $display("cube a=%0d y=%0d lat=%0d", j * j * j, y, lat);
      total++;
      if (y !== 8'(j)) begin bad++; $display("FAIL cube_y a=%0d got=%0d exp=%0d", j * j * j, y, j); end
      total++;
      if (lat != LAT) begin bad++; $display("FAIL cube_lat a=%0d got=%0d exp=%0d", j * j * j, lat, LAT); end
    end
  endtask

  task automatic test_edges;
    int ea[6] = '{124, 125, 215, 216, 255, 0};
    int ey[6] = '{4, 5, 5, 6, 6, 0};
    logic [7:0] y; int lat;
    for (int i = 0; i < 6; i++) begin
      run_op(8'(ea[i]), y, lat);
      $display("edge a=%0d y=%0d lat=%0d", ea[i], y, lat);
      total++;
      if (y !== 8'(ey[i])) begin bad++; $display("FAIL edge_y a=%0d got=%0d exp=%0d", ea[i], y, ey[i]); end
    end
    for (int a = 0; a < 256; a++) begin
      run_op(8'(a), y, lat);
      total++;
      if (y !== 8'(ref_cbrt(a)) || lat != LAT) begin
        bad++;
        $display("FAIL sweep a=%0d got=%0d/%0d exp=%0d/%0d", a, y, lat, ref_cbrt(a), LAT);
      end
    end
  endtask

  task automatic test_random;
    logic [7:0] y; int lat; int a;
    for (int n = 0; n < 30; n++) begin
      a = int'($urandom_range(0, 255));
      run_op(8'(a), y, lat);
      $display("rand a=%0d y=%0d lat=%0d", a, y, lat);
      total++;
      if (y !== 8'(ref_cbrt(a)) || lat != LAT) begin
        bad++;
        $display("FAIL rand a=%0d got=%0d/%0d exp=%0d/%0d", a, y, lat, ref_cbrt(a), LAT);
      end
    end
  endtask

  task automatic test_back_to_back;
    logic [7:0] a0, a1; int lat, guard;
    a0 = 8'($urandom); a1 = 8'($urandom);
    @(negedge clk_i); start_i = 1'b1; a_bi = a0;
    @(negedge clk_i);
    lat = 0; guard = 0;
    while (busy_o === 1'b1 && guard < 100) begin
      lat++; guard++; a_bi = 8'($urandom);
      @(negedge clk_i);
    end
    $display("b2b first a=%0d y=%0d lat=%0d", a0, y_bo, lat);
    total++;
    if (y_bo !== 8'(ref_cbrt(int'(a0))) || lat != LAT) begin
      bad++; $display("FAIL b2b_first a=%0d got=%0d/%0d exp=%0d/%0d", a0, y_bo, lat, ref_cbrt(int'(a0)), LAT);
    end
    a_bi = a1;
    @(negedge clk_i);
    total++;
    if (busy_o !== 1'b1) begin bad++; $display("FAIL b2b_accept got=%0b exp=1", busy_o); end
    lat = 0; guard = 0;
    while (busy_o === 1'b1 && guard < 100) begin
      lat++; guard++; a_bi = 8'($urandom);
      @(negedge clk_i);
    end
    start_i = 1'b0;
    $display("b2b second a=%0d y=%0d lat=%0d", a1, y_bo, lat);
    total++;
    if (y_bo !== 8'(ref_cbrt(int'(a1))) || lat != LAT) begin
      bad++; $display("FAIL b2b_second a=%0d got=%0d/%0d exp=%0d/%0d", a1, y_bo, lat, ref_cbrt(int'(a1)), LAT);
    end
    guard = 0;
    @(negedge clk_i);
    while (busy_o === 1'b1 && guard < 100) begin guard++; @(negedge clk_i); end
  endtask

  task automatic test_ignore_start;
    logic [7:0] a0; int lat, guard;
    a0 = 8'($urandom_range(8, 255));
    @(negedge clk_i); start_i = 1'b1; a_bi = a0;
    @(negedge clk_i); start_i = 1'b0;
    lat = 0; guard = 0;
    while (busy_o === 1'b1 && guard < 100) begin
      lat++; guard++;
      if (lat == 10) begin start_i = 1'b1; a_bi = 8'd3; end
      else start_i = 1'b0;
      @(negedge clk_i);
    end
    start_i = 1'b0;
    $display("ignore a=%0d y=%0d lat=%0d", a0, y_bo, lat);
    total++;
    if (y_bo !== 8'(ref_cbrt(int'(a0))) || lat != LAT) begin
      bad++; $display("FAIL ignore a=%0d got=%0d/%0d exp=%0d/%0d", a0, y_bo, lat, ref_cbrt(int'(a0)), LAT);
    end
    @(negedge clk_i);
    total++;
    if (busy_o !== 1'b0) begin bad++; $display("FAIL ignore_queued got=%0b exp=0", busy_o); end
  endtask

  task automatic test_reset_mid;
    logic [7:0] y; int lat;
    run_op(8'd125, y, lat);
    @(negedge clk_i); start_i = 1'b1; a_bi = 8'd64;
    @(negedge clk_i); start_i = 1'b0;
    lat = 1;
    while (lat < 15) begin lat++; @(negedge clk_i); end
    rst_i = 1'b1;
    @(negedge clk_i); rst_i = 1'b0;
    $display("rst_mid busy=%0b y=%0d", busy_o, y_bo);
    total++;
    if (busy_o !== 1'b0) begin bad++; $display("FAIL rstmid_busy got=%0b exp=0", busy_o); end
    total++;
    if (y_bo !== 8'd0) begin bad++; $display("FAIL rstmid_y got=%0d exp=0", y_bo); end
    run_op(8'd27, y, lat);
    $display("rst_mid fresh a=27 y=%0d lat=%0d", y, lat);
    total++;
    if (y !== 8'd3 || lat != LAT) begin bad++; $display("FAIL rstmid_fresh got=%0d/%0d exp=3/%0d", y, lat, LAT); end
  endtask

  task automatic test_chain;
    logic [7:0] y; int lat;
    for (int j = 0; j <= 4; j++) begin
      for (int i = 0; i < 16; i++) begin
        run_op(8'(j * j * j), y, lat);
        total++;
        if (ref_isqrt(i + int'(y)) != ref_isqrt(i + j)) begin
          bad++; $display("FAIL chain i=%0d j=%0d got=%0d exp=%0d", i, j, ref_isqrt(i + int'(y)), ref_isqrt(i + j));
        end
      end
      $display("chain j=%0d cbrt=%0d", j, y);
    end
  endtask

  initial begin
    rst_i = 1'b1; start_i = 1'b0; a_bi = '0;
    test_reset;
    test_cubes;
    test_edges;
    test_random;
    test_back_to_back;
    test_ignore_start;
    test_reset_mid;
    test_chain;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "timeout");
  end

endmodule
